parity_stream_checker: RTL
==========================

# parity_stream_checker

Streaming, parametrised parity generator/checker. Each accepted beat carries a WIDTH-bit data word plus its received parity bit. The block generates the parity of every word, counts parity mismatches, and accumulates frame-wide parity up to an end-of-frame marker. It then presents one registered frame report through a valid/ready handshake. It sits between a framed data source and the error/statistics logic, and supersedes the fixed 3-input combinational parity function with a width- and mode-configurable, frame-aware block.

## Interface
- WIDTH, 8, data word width (≥1)
- ODD, 1, parity sense: 1 = odd parity (data plus parity bit has an odd count of ones), 0 = even
- CNT_W, 8, width of the beat and error counters (≥2)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  source beat valid
- in_ready  output  1  block accepts the beat this cycle
- in_data  input  WIDTH  data word
- in_par  input  1  received parity bit for in_data
- in_last  input  1  beat is the final beat of its frame
- gen_par  output  1  combinational: ^in_data ^ ODD (valid whenever in_data is stable; independent of handshake)
- out_valid  output  1  frame report valid
- out_ready  input  1  sink accepts report
- out_par  output  1  frame parity: XOR of every data bit in the frame ^ ODD
- out_beats  output  CNT_W  beats in frame, saturating
- out_errs  output  CNT_W  beats with in_par ≠ gen_par, saturating
- out_ok  output  1  out_errs == 0

## Operation
- Beat accepted ⇔ in_valid && in_ready. in_ready = (state != HOLD) || out_ready.
- Per accepted beat: acc_par ^= ^in_data; acc_beats += 1 (saturate at 2^CNT_W−1); acc_errs += (in_par != gen_par) (saturate likewise).
- States:
  - IDLE: no frame open, accumulators zero. Accepted beat with in_last=0 → ACCUM. Accepted beat with in_last=1 → HOLD.
  - ACCUM: frame open. Accepted beat with in_last=1 → HOLD. Otherwise stay in ACCUM.
  - HOLD: report registered, out_valid=1, outputs stable until out_ready.
    - out_ready without an accepted beat → IDLE.
    - out_ready with an accepted beat: the beat starts a new frame from cleared accumulators (beats=1) → ACCUM, or → HOLD with the new report if in_last=1.
- Entering HOLD loads out_par = acc_par ^ ^in_data ^ ODD, plus out_beats/out_errs including the last beat. Accumulators then clear.
- out_ok is derived from the registered out_errs.
- Saturated counters hold at the all-ones value. No wrap.
- in_valid=0 never changes state or accumulators. in_data/in_par/in_last are ignored when the beat is not accepted.

## Timing
- Reset (synchronous, dominant over all other inputs): state=IDLE, out_valid=0, out_par=0, out_beats=0, out_errs=0, out_ok=1, accumulators zero. in_ready=1 in the first cycle after reset.
- Reset in mid-frame or while in HOLD discards the open frame and any pending report.
- Latency: report out_valid rises on the clock edge that accepts the last beat, i.e. visible one cycle after the last beat is presented.
- Throughput: one beat per cycle sustained, including back-to-back single-beat frames when out_ready is held 1.
- Backpressure: while in HOLD with out_ready=0, in_ready=0. No beat is lost or double-counted.
- gen_par: zero-cycle combinational path from in_data.

## Test plan
- WIDTH=3, ODD=1, single-beat frames, in_data sweeps 0..7 with in_par=gen_par, out_ready=1 → gen_par = 1,0,0,1,0,1,1,0; each report has out_beats=1, out_errs=0, out_ok=1, out_par=gen_par; one report per cycle.
- WIDTH=8, ODD=0, 4-beat frame 0x01,0x03,0x07,0x0F with correct in_par → out_par=0 (10 ones), out_beats=4, out_errs=0, out_valid one cycle after the last beat.
- Same frame with in_par inverted on beats 2 and 4 → out_errs=2, out_ok=0, out_par unchanged.
- Report held with out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout, outputs stable; on out_ready=1 the pending beat is accepted that same cycle and opens a new frame with beats=1.
- CNT_W=2, 6-beat frame with all parity bits wrong → out_beats=3, out_errs=3 (saturated).
- Reset asserted on the 3rd beat of a 5-beat frame, then a fresh 2-beat frame → out_valid=0 during reset; the next report shows out_beats=2 with no residue from the aborted frame.

Source files
------------

// File: rtl/parity_stream_checker.sv
// parity_stream_checker
//
// Streaming parity generator/checker with frame reports. Each accepted beat
// carries a WIDTH-bit word and its received parity bit. The block computes the
// parity of every word, counts beats whose received parity disagrees with the
// generated parity, and folds every data bit into a frame-wide parity. When the
// last beat of a frame is accepted, one registered report is held on a
// valid/ready handshake until the sink takes it.
//
// Parameters:
//   WIDTH  data word width (>= 1)
//   ODD    parity sense: 1 = odd parity, 0 = even parity
//   CNT_W  width of the saturating beat/error counters (>= 2)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   source beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_data    data word
//   in_par     received parity bit for in_data
//   in_last    final beat of the frame
//   gen_par    combinational parity of in_data (handshake independent)
//   out_valid  frame report valid
//   out_ready  sink accepts the report
//   out_par    frame parity over all data bits, with ODD applied
//   out_beats  beats in the frame, saturating
//   out_errs   beats with a parity mismatch, saturating
//   out_ok     no parity mismatches in the frame
module parity_stream_checker #(
    parameter int unsigned WIDTH = 8,
    parameter bit          ODD   = 1'b1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             in_last,
    output logic             gen_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par,
    output logic [CNT_W-1:0] out_beats,
    output logic [CNT_W-1:0] out_errs,
    output logic             out_ok
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic             r_acc_par;
    logic [CNT_W-1:0] r_acc_beats;
    logic [CNT_W-1:0] r_acc_errs;

    logic             r_out_par;
    logic [CNT_W-1:0] r_out_beats;
    logic [CNT_W-1:0] r_out_errs;

    logic             w_data_par;
    logic             w_accept;
    logic             w_beat_err;
    logic             w_par_inc;
    logic [CNT_W-1:0] w_beats_inc;
    logic [CNT_W-1:0] w_errs_inc;

    assign w_data_par = ^in_data;
    assign gen_par    = w_data_par ^ ODD;

    // A held report blocks new beats only until the sink takes it; the beat
    // presented in the release cycle is accepted in that same cycle.
    assign in_ready   = (r_state != StHold) || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_beat_err = (in_par != gen_par);

    // Accumulators are always zero in StIdle and StHold, so the same update
    // path both continues an open frame and starts a fresh one.
    assign w_par_inc   = r_acc_par ^ w_data_par;
    assign w_beats_inc = (r_acc_beats == '1) ? r_acc_beats : r_acc_beats + CNT_W'(1);
    assign w_errs_inc  = (w_beat_err && (r_acc_errs != '1)) ? r_acc_errs + CNT_W'(1)
                                                            : r_acc_errs;

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = in_last ? StHold : StAccum;
        end else if ((r_state == StHold) && out_ready) begin
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_acc_par   <= 1'b0;
            r_acc_beats <= '0;
            r_acc_errs  <= '0;
            r_out_par   <= 1'b0;
            r_out_beats <= '0;
            r_out_errs  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (in_last) begin
                    r_out_par   <= w_par_inc ^ ODD;
                    r_out_beats <= w_beats_inc;
                    r_out_errs  <= w_errs_inc;
                    r_acc_par   <= 1'b0;
                    r_acc_beats <= '0;
                    r_acc_errs  <= '0;
                end else begin
                    r_acc_par   <= w_par_inc;
                    r_acc_beats <= w_beats_inc;
                    r_acc_errs  <= w_errs_inc;
                end
            end
        end
    end

    assign out_valid = (r_state == StHold);
    assign out_par   = r_out_par;
    assign out_beats = r_out_beats;
    assign out_errs  = r_out_errs;
    assign out_ok    = (r_out_errs == '0);

endmodule
